// File: rtl/fp_mul_arbiter.sv
// Round-robin front end sharing one fixed-latency pipelined FP32 multiplier.
// Tracks issued operations with an ID tag pipeline and steers results back.
module fp_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int MUL_LATENCY = 3
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_b,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic                                 flush,
   output logic [DATA_WIDTH-1:0]                mul_a,
   output logic [DATA_WIDTH-1:0]                mul_b,
   input  logic [DATA_WIDTH-1:0]                mul_result,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output logic [DATA_WIDTH-1:0]                rsp_data,
   output logic                                 busy,
   output logic [$clog2(MUL_LATENCY+2)-1:0]     inflight
);

   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MUL_LATENCY + 2);

   if (DATA_WIDTH != 32) begin : g_bad_width
      $fatal(1, "fp_mul_arbiter: DATA_WIDTH must be 32");
   end

   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d;
   logic [DATA_WIDTH-1:0] mul_b_q, mul_b_d;
   logic [MUL_LATENCY:0]  tag_v_q, tag_v_d;
   logic [ID_W-1:0]       tag_id_q [MUL_LATENCY+1];
   logic [ID_W-1:0]       tag_id_d [MUL_LATENCY+1];

   logic                  gnt_found_s;
   logic [ID_W-1:0]       gnt_id_s;
   int                    cand_s;
   logic                  hs_s;
   logic [CNT_W-1:0]      inflight_s;

   // Search requests starting at the round-robin pointer, wrapping modulo NUM_REQ.
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_id_s    = '0;
      cand_s      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s = int'(rr_ptr_q) + k;
         if (cand_s >= NUM_REQ) begin
            cand_s = cand_s - NUM_REQ;
         end else begin
            cand_s = cand_s;
         end
         if (!gnt_found_s && req_valid[cand_s]) begin
            gnt_found_s = 1'b1;
            gnt_id_s    = ID_W'(cand_s);
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   // Grant is suppressed during reset and flush; the multiplier never stalls.
   always_comb begin
      req_ready = '0;
      if (rst_n && !flush && gnt_found_s) begin
         req_ready[gnt_id_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   assign hs_s = |(req_valid & req_ready);

   // Next-state for pointer, operand registers and the ID tag pipeline.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      mul_a_d  = '0;
      mul_b_d  = '0;
      if (hs_s) begin
         rr_ptr_d = (gnt_id_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
         mul_a_d  = req_a[gnt_id_s*DATA_WIDTH +: DATA_WIDTH];
         mul_b_d  = req_b[gnt_id_s*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      tag_v_d[0]  = hs_s;
      tag_id_d[0] = gnt_id_s;
      for (int k = 1; k <= MUL_LATENCY; k++) begin
         tag_v_d[k]  = tag_v_q[k-1];
         tag_id_d[k] = tag_id_q[k-1];
      end
      if (flush) begin
         tag_v_d = '0;
      end else begin
         tag_v_d = tag_v_d;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         tag_v_q  <= '0;
         for (int k = 0; k <= MUL_LATENCY; k++) begin
            tag_id_q[k] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         tag_v_q  <= tag_v_d;
         for (int k = 0; k <= MUL_LATENCY; k++) begin
            tag_id_q[k] <= tag_id_d[k];
         end
      end
   end

   // The last tag stage lines up with mul_result and drives the response pulse.
   always_comb begin
      rsp_valid = '0;
      if (rst_n && !flush && tag_v_q[MUL_LATENCY]) begin
         rsp_valid[tag_id_q[MUL_LATENCY]] = 1'b1;
      end else begin
         rsp_valid = '0;
      end
   end

   // Population count of valid tag entries.
   always_comb begin
      inflight_s = '0;
      for (int k = 0; k <= MUL_LATENCY; k++) begin
         inflight_s = inflight_s + CNT_W'(tag_v_q[k]);
      end
   end

   assign mul_a    = mul_a_q;
   assign mul_b    = mul_b_q;
   assign rsp_data = mul_result;
   assign inflight = inflight_s;
   assign busy     = |tag_v_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench: hand-built vector table, directed corner sequences and
// random traffic against a queue-based reference model with a stub multiplier.
module tb_fp_mul_arbiter;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req_valid;
   logic [127:0]  req_a;
   logic [127:0]  req_b;
   logic [3:0]    req_ready;
   logic          flush;
   logic [31:0]   mul_a;
   logic [31:0]   mul_b;
   logic [31:0]   mul_result;
   logic [3:0]    rsp_valid;
   logic [31:0]   rsp_data;
   logic          busy;
   logic [2:0]    inflight;

   fp_mul_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MUL_LATENCY(3)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .flush(flush), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .busy(busy), .inflight(inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Truncating FP32 multiply for normal operands.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [23:0] ma, mb;
      logic [47:0] m;
      logic [8:0]  e;
      logic [22:0] f;
      ma = {1'b1, a[22:0]};
      mb = {1'b1, b[22:0]};
      m  = ma * mb;
      e  = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
      if (m[47]) begin
         f = m[46:24];
         e = e + 9'd1;
      end else begin
         f = m[45:23];
      end
      return {a[31] ^ b[31], e[7:0], f};
   endfunction

   // Multiplier stand-in: three register stages, no stall.
   logic [31:0] p1, p2;
   always @(posedge clk) begin
      p1         <= fmul(mul_a, mul_b);
      p2         <= p1;
      mul_result <= p2;
   end

   function automatic logic [31:0] rfp();
      logic [31:0] r;
      r[31]    = 1'($urandom_range(0, 1));
      r[30:23] = 8'($urandom_range(100, 154));
      r[22:0]  = 23'($urandom);
      return r;
   endfunction

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model state
   typedef struct {
      int          id;
      logic [31:0] d;
      int          due;
   } op_t;
   op_t         pend[$];
   int          m_ptr = 0;
   logic [31:0] m_last_a = 32'd0;
   logic [31:0] m_last_b = 32'd0;
   bit          rand_ops = 1'b1;

   logic [3:0]  s_ready, s_rsp;
   logic [31:0] s_data, s_mul_a;
   logic        s_busy;
   logic [2:0]  s_inflight;

   // One clock cycle: drive, predict, sample at negedge, check, advance model.
   task automatic run_cycle(input logic [3:0] vld, input logic fl, input logic rn);
      int          g;
      int          idx;
      int          cnt;
      logic [3:0]  e_ready, e_rsp;
      logic [31:0] e_data;
      op_t         o;
      req_valid = vld;
      flush     = fl;
      rst_n     = rn;
      if (rand_ops) begin
         for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = rfp();
            req_b[i*32 +: 32] = rfp();
         end
      end
      g = -1;
      for (int k = 0; k < 4; k++) begin
         idx = (m_ptr + k) % 4;
         if (g < 0 && vld[idx]) g = idx;
      end
      e_ready = 4'd0;
      if (rn && !fl && g >= 0) e_ready = 4'(1 << g);
      e_rsp  = 4'd0;
      e_data = 32'd0;
      cnt    = 0;
      foreach (pend[i]) begin
         if (pend[i].due >= cyc) cnt++;
         if (pend[i].due == cyc && rn && !fl) begin
            e_rsp  = 4'(1 << pend[i].id);
            e_data = pend[i].d;
         end
      end
      @(negedge clk);
      s_ready    = req_ready;
      s_rsp      = rsp_valid;
      s_data     = rsp_data;
      s_mul_a    = mul_a;
      s_busy     = busy;
      s_inflight = inflight;
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      if (e_rsp != 4'd0) check("rsp_data", rsp_data, e_data);
      check("mul_a", mul_a, m_last_a);
      check("mul_b", mul_b, m_last_b);
      check("inflight", 32'(inflight), 32'(cnt));
      check("busy", 32'(busy), 32'(cnt != 0));
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
      if (!rn) begin
         pend.delete();
         m_ptr    = 0;
         m_last_a = 32'd0;
         m_last_b = 32'd0;
      end else if (fl || g < 0) begin
         if (fl) pend.delete();
         m_last_a = 32'd0;
         m_last_b = 32'd0;
      end else begin
         o.id  = g;
         o.d   = fmul(req_a[g*32 +: 32], req_b[g*32 +: 32]);
         o.due = cyc + 4;
         pend.push_back(o);
         m_ptr    = (g + 1) % 4;
         m_last_a = req_a[g*32 +: 32];
         m_last_b = req_b[g*32 +: 32];
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] vld;
      logic       fl;
      logic [3:0] exp_ready;
      logic [3:0] exp_rsp;
   } vec_t;
   vec_t tbl[15];

   initial begin
      tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 4'b0000};
      tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 4'b0000};
      tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 4'b0000};
      tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 4'b0000};
      tbl[4]  = '{4'b1010, 1'b0, 4'b0010, 4'b0001};
      tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 4'b0010};
      tbl[6]  = '{4'b1011, 1'b0, 4'b1000, 4'b0100};
      tbl[7]  = '{4'b0110, 1'b0, 4'b0010, 4'b1000};
      tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000};
      tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000};
      tbl[10] = '{4'b0001, 1'b0, 4'b0001, 4'b0000};
      tbl[11] = '{4'b0100, 1'b0, 4'b0100, 4'b0000};
      tbl[12] = '{4'b0010, 1'b0, 4'b0010, 4'b0000};
      tbl[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0001};
      tbl[14] = '{4'b1001, 1'b0, 4'b1000, 4'b0001};

      rst_n     = 1'b0;
      flush     = 1'b0;
      req_valid = 4'b1111;
      req_a     = '0;
      req_b     = '0;
      @(posedge clk);
      #1;

      // Reset held with all requests valid
      for (int i = 0; i < 2; i++) begin
         run_cycle(4'b1111, 1'b0, 1'b0);
         check("rst_ready", 32'(s_ready), 32'd0);
         check("rst_rsp", 32'(s_rsp), 32'd0);
         check("rst_busy", 32'(s_busy), 32'd0);
      end

      // Vector table: fairness, sparse wrap, idle, flush
      for (int i = 0; i < 15; i++) begin
         run_cycle(tbl[i].vld, tbl[i].fl, 1'b1);
         check("tbl_ready", 32'(s_ready), 32'(tbl[i].exp_ready));
         check("tbl_rsp", 32'(s_rsp), 32'(tbl[i].exp_rsp));
      end
      for (int i = 0; i < 5; i++) run_cycle(4'b0000, 1'b0, 1'b1);
      check("drain_busy", 32'(s_busy), 32'd0);

      // Single op: 2.0 * 3.0 from requester 2
      rand_ops = 1'b0;
      req_a = '0;
      req_b = '0;
      req_a[2*32 +: 32] = 32'h4000_0000;
      req_b[2*32 +: 32] = 32'h4040_0000;
      run_cycle(4'b0100, 1'b0, 1'b1);
      check("single_ready", 32'(s_ready), 32'h4);
      run_cycle(4'b0000, 1'b0, 1'b1);
      check("single_mul_a", s_mul_a, 32'h4000_0000);
      for (int i = 0; i < 2; i++) begin
         run_cycle(4'b0000, 1'b0, 1'b1);
         check("single_quiet", 32'(s_rsp), 32'd0);
      end
      run_cycle(4'b0000, 1'b0, 1'b1);
      check("single_rsp", 32'(s_rsp), 32'h4);
      check("single_data", s_data, 32'h40C0_0000);
      rand_ops = 1'b1;

      // Flush mid-flight
      for (int i = 0; i < 3; i++) run_cycle(4'b1111, 1'b0, 1'b1);
      run_cycle(4'b1111, 1'b1, 1'b1);
      check("flush_ready", 32'(s_ready), 32'd0);
      check("flush_rsp", 32'(s_rsp), 32'd0);
      run_cycle(4'b0001, 1'b0, 1'b1);
      check("flush_busy", 32'(s_busy), 32'd0);
      check("flush_rsp4", 32'(s_rsp), 32'd0);
      check("post_flush_ready", 32'(s_ready), 32'h1);
      for (int i = 0; i < 3; i++) begin
         run_cycle(4'b0000, 1'b0, 1'b1);
         check("post_flush_quiet", 32'(s_rsp), 32'd0);
      end
      run_cycle(4'b0000, 1'b0, 1'b1);
      check("post_flush_rsp", 32'(s_rsp), 32'h1);

      // Reset mid-flight
      for (int i = 0; i < 3; i++) run_cycle(4'b1111, 1'b0, 1'b1);
      run_cycle(4'b1111, 1'b0, 1'b0);
      check("midrst_rsp", 32'(s_rsp), 32'd0);
      for (int i = 0; i < 4; i++) begin
         run_cycle(4'b0000, 1'b0, 1'b1);
         check("midrst_quiet", 32'(s_rsp), 32'd0);
         if (i == 0) check("midrst_inflight", 32'(s_inflight), 32'd0);
      end

      // Sustained round-robin burst from pointer 0
      for (int i = 0; i < 8; i++) begin
         run_cycle(4'b1111, 1'b0, 1'b1);
         check("rr_grant", 32'(s_ready), 32'(1 << (i % 4)));
         if (i >= 4) begin
            check("rr_inflight", 32'(s_inflight), 32'd4);
            check("rr_rsp", 32'(s_rsp), 32'(1 << (i % 4)));
         end
      end
      for (int j = 0; j < 4; j++) begin
         run_cycle(4'b0000, 1'b0, 1'b1);
         check("rr_tail_rsp", 32'(s_rsp), 32'(1 << j));
      end

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         run_cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0),
                   !($urandom_range(0, 63) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
